// File: rtl/la32_mc_core.sv
// la32_mc_core: multi-cycle LA32R integer core, one instruction in flight.
// Fetch and data ports use req/gnt/rvalid so either memory may stall.
module la32_mc_core #(
  parameter logic [31:0] RESET_PC  = 32'h1c000000,
  parameter int          DBG_WE_W  = 4,
  parameter int          MAX_OUTST = 1
) (
  input  logic                clk,
  input  logic                reset,
  output logic                inst_req,
  output logic [31:0]         inst_addr,
  input  logic                inst_gnt,
  input  logic                inst_rvalid,
  input  logic [31:0]         inst_rdata,
  output logic                data_req,
  output logic                data_we,
  output logic [31:0]         data_addr,
  output logic [31:0]         data_wdata,
  input  logic                data_gnt,
  input  logic                data_rvalid,
  input  logic [31:0]         data_rdata,
  output logic                ill_inst,
  output logic [31:0]         debug_wb_pc,
  output logic [DBG_WE_W-1:0] debug_wb_rf_we,
  output logic [4:0]          debug_wb_rf_wnum,
  output logic [31:0]         debug_wb_rf_wdata
);

  typedef enum logic [2:0] {
    F_REQ, F_WAIT, EXEC, M_REQ, M_WAIT, RETIRE
  } state_e;

  // The FSM state itself is the single outstanding-request tracker.
  localparam bit OUTST_OK = (MAX_OUTST >= 1);

  state_e        state_q;
  logic [31:0]   pc_q, npc_q, ir_q;
  logic          inst_req_q, data_req_q, data_we_q;
  logic [31:0]   data_addr_q, data_wdata_q;
  logic          m_wr_q;
  logic [4:0]    m_wnum_q;
  logic          ill_q;
  logic [31:0]   dbg_pc_q, dbg_wdata_q;
  logic [DBG_WE_W-1:0] dbg_we_q;
  logic [4:0]    dbg_wnum_q;
  logic [31:0]   rf_q [32];

  assign inst_req          = inst_req_q & OUTST_OK;
  assign inst_addr         = pc_q;
  assign data_req          = data_req_q & OUTST_OK;
  assign data_we           = data_we_q;
  assign data_addr         = data_addr_q;
  assign data_wdata        = data_wdata_q;
  assign ill_inst          = ill_q;
  assign debug_wb_pc       = dbg_pc_q;
  assign debug_wb_rf_we    = dbg_we_q;
  assign debug_wb_rf_wnum  = dbg_wnum_q;
  assign debug_wb_rf_wdata = dbg_wdata_q;

  logic [4:0]  rd, rj, rk;
  logic [31:0] rd_v, rj_v, rk_v;
  logic [31:0] si12, off16, off26, pc4;
  logic [16:0] op17;
  logic [9:0]  op10;
  logic [6:0]  op7;
  logic [5:0]  op6;

  assign rd    = ir_q[4:0];
  assign rj    = ir_q[9:5];
  assign rk    = ir_q[14:10];
  assign op17  = ir_q[31:15];
  assign op10  = ir_q[31:22];
  assign op7   = ir_q[31:25];
  assign op6   = ir_q[31:26];
  assign rd_v  = (rd == 5'd0) ? '0 : rf_q[rd];
  assign rj_v  = (rj == 5'd0) ? '0 : rf_q[rj];
  assign rk_v  = (rk == 5'd0) ? '0 : rf_q[rk];
  assign si12  = {{20{ir_q[21]}}, ir_q[21:10]};
  assign off16 = {{14{ir_q[25]}}, ir_q[25:10], 2'b00};
  assign off26 = {{4{ir_q[9]}}, ir_q[9:0], ir_q[25:10], 2'b00};
  assign pc4   = pc_q + 32'd4;

  logic [31:0] ex_res, ex_npc;
  logic [4:0]  ex_wnum;
  logic        ex_wen, ex_ill, ex_mem, ex_st, ex_wr;

  always_comb begin
    ex_res  = '0;
    ex_npc  = pc4;
    ex_wnum = rd;
    ex_wen  = 1'b0;
    ex_ill  = 1'b0;
    ex_mem  = 1'b0;
    ex_st   = 1'b0;
    unique case (1'b1)
      op17 == 17'h00020: begin
        ex_res = rj_v + rk_v; ex_wen = 1'b1;
      end
      op17 == 17'h00022: begin
        ex_res = rj_v - rk_v; ex_wen = 1'b1;
      end
      op17 == 17'h00024: begin
        ex_res = {31'd0, $signed(rj_v) < $signed(rk_v)};
        ex_wen = 1'b1;
      end
      op17 == 17'h00025: begin
        ex_res = {31'd0, rj_v < rk_v}; ex_wen = 1'b1;
      end
      op17 == 17'h00028: begin
        ex_res = ~(rj_v | rk_v); ex_wen = 1'b1;
      end
      op17 == 17'h00029: begin
        ex_res = rj_v & rk_v; ex_wen = 1'b1;
      end
      op17 == 17'h0002a: begin
        ex_res = rj_v | rk_v; ex_wen = 1'b1;
      end
      op17 == 17'h0002b: begin
        ex_res = rj_v ^ rk_v; ex_wen = 1'b1;
      end
      op17 == 17'h00081: begin
        ex_res = rj_v << rk; ex_wen = 1'b1;
      end
      op17 == 17'h00089: begin
        ex_res = rj_v >> rk; ex_wen = 1'b1;
      end
      op17 == 17'h00091: begin
        ex_res = $signed(rj_v) >>> rk; ex_wen = 1'b1;
      end
      op10 == 10'h00a: begin
        ex_res = rj_v + si12; ex_wen = 1'b1;
      end
      op10 == 10'h0a2: begin
        ex_mem = 1'b1; ex_wen = 1'b1;
      end
      op10 == 10'h0a6: begin
        ex_mem = 1'b1; ex_st = 1'b1;
      end
      op6 == 6'h13: begin
        ex_res = pc4; ex_wen = 1'b1;
        ex_npc = rj_v + off16;
      end
      op6 == 6'h14: ex_npc = pc_q + off26;
      op6 == 6'h15: begin
        ex_res = pc4; ex_wen = 1'b1;
        ex_wnum = 5'd1; ex_npc = pc_q + off26;
      end
      op6 == 6'h16:
        if (rj_v == rd_v) ex_npc = pc_q + off16;
      op6 == 6'h17:
        if (rj_v != rd_v) ex_npc = pc_q + off16;
      op7 == 7'h0a: begin
        ex_res = {ir_q[24:5], 12'd0}; ex_wen = 1'b1;
      end
      default: ex_ill = 1'b1;
    endcase
  end

  assign ex_wr = ex_wen && (ex_wnum != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= F_REQ;
      pc_q         <= RESET_PC;
      npc_q        <= RESET_PC;
      ir_q         <= '0;
      inst_req_q   <= 1'b0;
      data_req_q   <= 1'b0;
      data_we_q    <= 1'b0;
      data_addr_q  <= '0;
      data_wdata_q <= '0;
      m_wr_q       <= 1'b0;
      m_wnum_q     <= '0;
      ill_q        <= 1'b0;
      dbg_pc_q     <= '0;
      dbg_we_q     <= '0;
      dbg_wnum_q   <= '0;
      dbg_wdata_q  <= '0;
    end else begin
      ill_q    <= 1'b0;
      dbg_we_q <= '0;
      unique case (state_q)
        F_REQ: begin
          if (inst_req && inst_gnt) begin
            inst_req_q <= 1'b0;
            state_q    <= F_WAIT;
          end else begin
            inst_req_q <= 1'b1;
          end
        end
        F_WAIT: begin
          if (inst_rvalid) begin
            ir_q    <= inst_rdata;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          npc_q    <= ex_npc;
          m_wr_q   <= ex_wr;
          m_wnum_q <= ex_wnum;
          if (ex_mem) begin
            data_req_q   <= 1'b1;
            data_we_q    <= ex_st;
            data_addr_q  <= rj_v + si12;
            data_wdata_q <= ex_st ? rd_v : '0;
            state_q      <= M_REQ;
          end else begin
            dbg_pc_q    <= pc_q;
            dbg_we_q    <= {DBG_WE_W{ex_wr}};
            dbg_wnum_q  <= ex_wr ? ex_wnum : '0;
            dbg_wdata_q <= ex_wr ? ex_res : '0;
            ill_q       <= ex_ill;
            state_q     <= RETIRE;
          end
        end
        M_REQ: begin
          if (data_req && data_gnt) begin
            data_req_q <= 1'b0;
            data_we_q  <= 1'b0;
            state_q    <= M_WAIT;
          end
        end
        M_WAIT: begin
          if (data_rvalid) begin
            dbg_pc_q    <= pc_q;
            dbg_we_q    <= {DBG_WE_W{m_wr_q}};
            dbg_wnum_q  <= m_wr_q ? m_wnum_q : '0;
            dbg_wdata_q <= m_wr_q ? data_rdata : '0;
            state_q     <= RETIRE;
          end
        end
        RETIRE: begin
          pc_q       <= npc_q;
          inst_req_q <= 1'b1;
          state_q    <= F_REQ;
        end
        default: state_q <= F_REQ;
      endcase
    end
  end

  // Write-back reuses the debug registers, which already hold r0 suppression.
  always_ff @(posedge clk) begin
    if (!reset && state_q == RETIRE && dbg_we_q[0])
      rf_q[dbg_wnum_q] <= dbg_wdata_q;
  end

endmodule

// File: tb/tb_la32_mc_core.sv
// tb_la32_mc_core: directed program with fetch, data and write-back
// scoreboards fed by stimulus and drained by a negedge monitor.
module tb_la32_mc_core;
  localparam logic [31:0] RPC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_gnt, inst_rvalid;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_we, data_gnt, data_rvalid;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        ill_inst;
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;

  always #5 clk = ~clk;

  la32_mc_core #(
    .RESET_PC(RPC), .DBG_WE_W(4), .MAX_OUTST(1)
  ) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_gnt(inst_gnt), .inst_rvalid(inst_rvalid),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_we(data_we),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .data_rdata(data_rdata),
    .ill_inst(ill_inst),
    .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  typedef struct {
    logic [31:0] pc;
    logic        wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
    logic        ill;
    int          lat;
  } wb_t;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dm_t;

  wb_t         wb_q[$];
  logic [31:0] fe_q[$];
  dm_t         dq[$];
  logic [31:0] imem [logic [31:0]];
  logic [31:0] dmem [64];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int gnt_cyc = 0;
  logic dm_holding = 1'b0;
  logic stale_go = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic ew(input logic [31:0] off, input logic [4:0] wn,
                    input logic [31:0] wd, input int lat);
    wb_t e;
    e.pc = RPC + off; e.wen = 1'b1; e.wnum = wn;
    e.wdata = wd; e.ill = 1'b0; e.lat = lat;
    wb_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // zero-wait instruction memory: gnt with req, rvalid next cycle
  assign inst_gnt = inst_req;
  initial begin
    logic        pend;
    logic [31:0] fa;
    pend = 1'b0; fa = '0;
    inst_rvalid = 1'b0; inst_rdata = '0;
    forever begin
      @(negedge clk);
      inst_rvalid = 1'b0;
      if (pend && !reset) begin
        inst_rvalid = 1'b1;
        inst_rdata = imem.exists(fa) ? imem[fa] : 32'h0;
      end
      pend = 1'b0;
      if (inst_req && inst_gnt) begin
        pend = 1'b1; fa = inst_addr;
      end
    end
  end

  // data memory: gnt after 3 cycles; third access is held for reset test
  initial begin
    logic        w, hold;
    logic [31:0] a, wd;
    int          n;
    n = 0;
    data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = '0;
    forever begin
      @(negedge clk);
      if (data_req && !reset) begin
        repeat (3) @(negedge clk);
        data_gnt = 1'b1;
        a = data_addr; w = data_we; wd = data_wdata;
        hold = (n == 2);
        n++;
        @(negedge clk);
        data_gnt = 1'b0;
        if (hold) begin
          dm_holding = 1'b1;
          while (!stale_go) @(negedge clk);
          dm_holding = 1'b0;
        end
        data_rvalid = 1'b1;
        data_rdata = hold ? 32'hdeadbeef :
                     w ? 32'h0 : dmem[a[7:2]];
        if (w) dmem[a[7:2]] = wd;
        @(negedge clk);
        data_rvalid = 1'b0;
      end
    end
  end

  // monitor
  initial begin
    logic        dh_act;
    logic [31:0] dh_addr, dh_wdata;
    logic        dh_we;
    dh_act = 1'b0; dh_addr = '0; dh_wdata = '0; dh_we = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        dh_act = 1'b0;
      end else begin
        if (inst_req && inst_gnt) begin
          gnt_cyc = cyc;
          if (fe_q.size() == 0) begin
            chk("fetch_unexpected", inst_addr, 32'hffffffff);
          end else begin
            chk("fetch_addr", inst_addr, fe_q.pop_front());
          end
        end
        if (data_req && !dh_act) begin
          dh_act = 1'b1; dh_we = data_we;
          dh_addr = data_addr; dh_wdata = data_wdata;
        end
        if (data_req && data_gnt) begin
          dh_act = 1'b0;
          if (dq.size() == 0) begin
            chk("dreq_unexpected", data_addr, 32'hffffffff);
          end else begin
            dm_t d;
            d = dq.pop_front();
            chk("dreq_we", {31'd0, data_we}, {31'd0, d.we});
            chk("dreq_addr", data_addr, d.addr);
            chk("dreq_hold_addr", dh_addr, d.addr);
            chk("dreq_hold_we", {31'd0, dh_we}, {31'd0, d.we});
            if (d.we) begin
              chk("dreq_wdata", data_wdata, d.wdata);
              chk("dreq_hold_wdata", dh_wdata, d.wdata);
            end
          end
        end
        if (debug_wb_rf_we != 4'h0 || ill_inst) begin
          if (wb_q.size() == 0) begin
            chk("wb_unexpected", debug_wb_pc, 32'hffffffff);
          end else begin
            wb_t e;
            e = wb_q.pop_front();
            chk("wb_pc", debug_wb_pc, e.pc);
            chk("wb_we", {28'd0, debug_wb_rf_we},
                e.wen ? 32'hf : 32'h0);
            chk("wb_ill", {31'd0, ill_inst}, {31'd0, e.ill});
            if (e.wen) begin
              chk("wb_wnum", {27'd0, debug_wb_rf_wnum},
                  {27'd0, e.wnum});
              chk("wb_wdata", debug_wb_rf_wdata, e.wdata);
            end
            if (e.lat >= 0)
              chk("wb_latency", cyc - gnt_cyc, e.lat);
          end
        end
      end
    end
  end

  initial begin
    wb_t il;
    dm_t d;
    int k;
    reset = 1'b1;
    foreach (dmem[i]) dmem[i] = '0;
    imem[RPC + 32'h000] = 32'h02801401;
    imem[RPC + 32'h004] = 32'h142468a2;
    imem[RPC + 32'h008] = 32'h00100843;
    imem[RPC + 32'h00c] = 32'h29804003;
    imem[RPC + 32'h010] = 32'h28804004;
    imem[RPC + 32'h014] = 32'h00110485;
    imem[RPC + 32'h018] = 32'h00408c26;
    imem[RPC + 32'h01c] = 32'h02800420;
    imem[RPC + 32'h020] = 32'h58000821;
    imem[RPC + 32'h024] = 32'h02801407;
    imem[RPC + 32'h028] = 32'h54010000;
    imem[RPC + 32'h128] = 32'hffffffff;
    imem[RPC + 32'h12c] = 32'h00128407;
    imem[RPC + 32'h130] = 32'h4c00402a;
    imem[RPC + 32'h06c] = 32'h2880400b;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_inst_req", {31'd0, inst_req}, 32'h0);
    chk("rst_inst_addr", inst_addr, RPC);
    chk("rst_data_req", {31'd0, data_req}, 32'h0);
    chk("rst_data_addr", data_addr, 32'h0);
    chk("rst_data_wdata", data_wdata, 32'h0);
    chk("rst_ill", {31'd0, ill_inst}, 32'h0);
    chk("rst_dbg_pc", debug_wb_pc, 32'h0);
    chk("rst_dbg_we", {28'd0, debug_wb_rf_we}, 32'h0);
    chk("rst_dbg_wdata", debug_wb_rf_wdata, 32'h0);

    foreach (imem[a]) k = 0;
    fe_q = '{RPC + 32'h000, RPC + 32'h004, RPC + 32'h008,
             RPC + 32'h00c, RPC + 32'h010, RPC + 32'h014,
             RPC + 32'h018, RPC + 32'h01c, RPC + 32'h020,
             RPC + 32'h028, RPC + 32'h128, RPC + 32'h12c,
             RPC + 32'h130, RPC + 32'h06c,
             RPC + 32'h000, RPC + 32'h004};
    ew(32'h000, 5'd1, 32'h00000005, 3);
    ew(32'h004, 5'd2, 32'h12345000, 3);
    ew(32'h008, 5'd3, 32'h2468a000, 3);
    ew(32'h010, 5'd4, 32'h2468a000, -1);
    ew(32'h014, 5'd5, 32'h24689ffb, 3);
    ew(32'h018, 5'd6, 32'h00000028, 3);
    ew(32'h028, 5'd1, 32'h1c00002c, 3);
    il.pc = RPC + 32'h128; il.wen = 1'b0; il.wnum = '0;
    il.wdata = '0; il.ill = 1'b1; il.lat = 3;
    wb_q.push_back(il);
    ew(32'h12c, 5'd7, 32'h00000001, 3);
    ew(32'h130, 5'd10, 32'h1c000134, 3);
    ew(32'h000, 5'd1, 32'h00000005, 3);
    d.we = 1'b1; d.addr = 32'h10; d.wdata = 32'h2468a000;
    dq.push_back(d);
    d.we = 1'b0; d.wdata = '0;
    dq.push_back(d);
    dq.push_back(d);

    reset = 1'b0;
    k = 0;
    while (k < 600 && !dm_holding) begin
      @(negedge clk);
      k++;
    end
    if (!dm_holding) begin
      n_vec++; n_err++;
      $display("FAIL reach_m_wait: got timeout expected hold");
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_inst_req", {31'd0, inst_req}, 32'h0);
    chk("mid_rst_data_req", {31'd0, data_req}, 32'h0);
    chk("mid_rst_inst_addr", inst_addr, RPC);
    reset = 1'b0;
    stale_go = 1'b1;

    k = 0;
    while (k < 300 &&
           (fe_q.size() != 0 || wb_q.size() != 0 ||
            dq.size() != 0)) begin
      @(negedge clk);
      k++;
    end
    chk("left_fetch", fe_q.size(), 0);
    chk("left_wb", wb_q.size(), 0);
    chk("left_data", dq.size(), 0);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
